vc_crossbar3_arbiter: RTL and testbench

//  Sequences a 3x3 domain-tagged crossbar: per-output round-robin arbitration

---
 rtl/vc_crossbar3_arbiter_pkg.sv | 45 ++++
 rtl/vc_crossbar3_arbiter_if.sv | 28 ++
 rtl/vc_crossbar3_out_arb.sv | 109 ++++++++++
 rtl/vc_crossbar3_arbiter.sv | 81 ++++++++
 tb/tb_vc_crossbar3_arbiter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/vc_crossbar3_arbiter_pkg.sv
// Shared types, domain/destination encodings and arbitration helpers for the
// 3x3 domain-tagged crossbar arbiter.
package vc_crossbar3_arbiter_pkg;

   localparam logic       DOMAIN_L  = 1'b0;
   localparam logic       DOMAIN_H  = 1'b1;
   localparam logic [1:0] DEST_NONE = 2'd3;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic       hit;
      logic [1:0] idx;
   } grant_t;

   // No-flow-down rule: only an H input into an L output is forbidden.
   function automatic logic domain_ok(input logic in_dom, input logic out_dom);
      return !(in_dom == DOMAIN_H && out_dom == DOMAIN_L);
   endfunction

   function automatic logic [1:0] next_rr(input logic [1:0] idx);
      return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

   // First eligible requester searching ptr, ptr+1, ptr+2 (mod 3).
   function automatic grant_t rr_pick(input logic [2:0] elig, input logic [1:0] ptr);
      grant_t     g;
      logic [2:0] s;
      logic [1:0] cand;
      g = '0;
      for (int k = 2; k >= 0; k--) begin
         s    = {1'b0, ptr} + 3'(k);
         cand = (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
         if (elig[cand]) begin
            g.hit = 1'b1;
            g.idx = cand;
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/vc_crossbar3_arbiter_if.sv
// Request/target handshake, crossbar select and violation-report bundle
// between the bus masters/targets and the crossbar arbiter.
interface vc_crossbar3_arbiter_if;
   logic [2:0] req_val;
   logic [5:0] req_dest;
   logic [2:0] req_last;
   logic [2:0] req_rdy;
   logic [2:0] in_domain;
   logic [2:0] out_domain;
   logic [2:0] out_val;
   logic [2:0] out_rdy;
   logic [1:0] sel0;
   logic [1:0] sel1;
   logic [1:0] sel2;
   logic       viol_val;
   logic [1:0] viol_src;
   logic [1:0] viol_dest;

   modport master (
      output req_val, req_dest, req_last, in_domain, out_domain, out_rdy,
      input  req_rdy, out_val, sel0, sel1, sel2, viol_val, viol_src, viol_dest
   );

   modport slave (
      input  req_val, req_dest, req_last, in_domain, out_domain, out_rdy,
      output req_rdy, out_val, sel0, sel1, sel2, viol_val, viol_src, viol_dest
   );
endinterface

// File: rtl/vc_crossbar3_out_arb.sv
// Per-output round-robin arbiter: grant FSM, beat counter with forced release,
// and rising-edge detection of domain violations aimed at this output.
module vc_crossbar3_out_arb
   import vc_crossbar3_arbiter_pkg::*;
#(
   parameter int         p_max_beats = 16,
   parameter logic [1:0] out_idx     = 2'd0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [2:0] req_val,
   input  logic [5:0] req_dest,
   input  logic [2:0] req_last,
   input  logic [2:0] in_domain,
   input  logic       out_domain,
   input  logic       out_rdy,
   output logic       out_val,
   output logic [2:0] rdy_grant,
   output logic [1:0] sel,
   output logic [2:0] viol_hit
);

   localparam int cnt_w = $clog2(p_max_beats + 1);

   arb_state_e        state_q, state_d;
   logic [1:0]        rr_q, rr_d;
   logic [1:0]        owner_q, owner_d;
   logic [cnt_w-1:0]  cnt_q, cnt_d;
   logic [2:0]        offense_q;
   logic [2:0]        targeted, eligible, offense;
   logic              allowed, fire, flip;
   grant_t            pick;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ARB_IDLE;
         rr_q      <= 2'd0;
         owner_q   <= 2'd0;
         cnt_q     <= '0;
         offense_q <= 3'b000;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         owner_q   <= owner_d;
         cnt_q     <= cnt_d;
         offense_q <= offense;
      end
   end

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         targeted[i] = req_val[i] && (req_dest[2*i +: 2] != DEST_NONE) &&
                       (req_dest[2*i +: 2] == out_idx);
         eligible[i] = targeted[i] && domain_ok(in_domain[i], out_domain);
         offense[i]  = targeted[i] && !domain_ok(in_domain[i], out_domain);
      end
   end

   assign pick    = rr_pick(eligible, rr_q);
   assign allowed = domain_ok(in_domain[owner_q], out_domain);
   assign sel     = owner_q;

   // An owner that loses permission mid-packet is dropped without moving a beat.
   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      owner_d   = owner_q;
      cnt_d     = cnt_q;
      out_val   = 1'b0;
      rdy_grant = 3'b000;
      fire      = 1'b0;
      flip      = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (pick.hit) begin
               state_d = ARB_BUSY;
               owner_d = pick.idx;
               cnt_d   = '0;
            end
         end
         ARB_BUSY: begin
            if (!allowed) begin
               flip    = 1'b1;
               state_d = ARB_IDLE;
               rr_d    = next_rr(owner_q);
            end else begin
               out_val            = req_val[owner_q];
               rdy_grant[owner_q] = out_rdy;
               fire               = req_val[owner_q] && out_rdy;
               if (fire) begin
                  if (req_last[owner_q] || (cnt_q == cnt_w'(p_max_beats - 1))) begin
                     state_d = ARB_IDLE;
                     rr_d    = next_rr(owner_q);
                  end else begin
                     cnt_d = cnt_q + cnt_w'(1);
                  end
               end
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_comb begin
      viol_hit = offense & ~offense_q;
      if (flip) viol_hit[owner_q] = 1'b1;
   end

endmodule

// File: rtl/vc_crossbar3_arbiter.sv
// 3x3 domain-tagged crossbar sequencer: three per-output arbiters, merged
// input-ready, and a registered lowest-input-first violation report.
module vc_crossbar3_arbiter
   import vc_crossbar3_arbiter_pkg::*;
#(
   parameter int p_max_beats = 16
) (
   input logic                   clk,
   input logic                   reset_n,
   vc_crossbar3_arbiter_if.slave bus
);

   logic [2:0] out_val_w;
   logic [2:0] rdy_grant [3];
   logic [2:0] viol_hit  [3];
   logic [1:0] sel_w     [3];
   logic       viol_any;
   logic [1:0] src_d, dest_d;
   logic       viol_val_q;
   logic [1:0] viol_src_q, viol_dest_q;

   for (genvar j = 0; j < 3; j++) begin : g_out
      vc_crossbar3_out_arb #(
         .p_max_beats (p_max_beats),
         .out_idx     (2'(j))
      ) u_arb (
         .clk        (clk),
         .reset_n    (reset_n),
         .req_val    (bus.req_val),
         .req_dest   (bus.req_dest),
         .req_last   (bus.req_last),
         .in_domain  (bus.in_domain),
         .out_domain (bus.out_domain[j]),
         .out_rdy    (bus.out_rdy[j]),
         .out_val    (out_val_w[j]),
         .rdy_grant  (rdy_grant[j]),
         .sel        (sel_w[j]),
         .viol_hit   (viol_hit[j])
      );
   end

   assign bus.out_val   = out_val_w;
   assign bus.req_rdy   = rdy_grant[0] | rdy_grant[1] | rdy_grant[2];
   assign bus.sel0      = sel_w[0];
   assign bus.sel1      = sel_w[1];
   assign bus.sel2      = sel_w[2];
   assign bus.viol_val  = viol_val_q;
   assign bus.viol_src  = viol_src_q;
   assign bus.viol_dest = viol_dest_q;

   // Scanned high-to-low so the lowest offending input ends up reported.
   always_comb begin
      viol_any = 1'b0;
      src_d    = 2'd0;
      dest_d   = 2'd0;
      for (int i = 2; i >= 0; i--) begin
         for (int j = 2; j >= 0; j--) begin
            if (viol_hit[j][i]) begin
               viol_any = 1'b1;
               src_d    = 2'(i);
               dest_d   = 2'(j);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         viol_val_q  <= 1'b0;
         viol_src_q  <= 2'd0;
         viol_dest_q <= 2'd0;
      end else begin
         viol_val_q <= viol_any;
         if (viol_any) begin
            viol_src_q  <= src_d;
            viol_dest_q <= dest_d;
         end
      end
   end

endmodule

// File: tb/tb_vc_crossbar3_arbiter.sv
// Directed bench for vc_crossbar3_arbiter with p_max_beats=4: reset, contention,
// flow-down blocking, domain flip, backpressure, forced release, mid-packet reset.
module tb_vc_crossbar3_arbiter;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;
   int   errors  = 0;
   int   checks  = 0;
   int   fires   = 0;
   int   own_seq [4];

   vc_crossbar3_arbiter_if bus ();

   vc_crossbar3_arbiter #(.p_max_beats(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic [2:0] val, input logic [5:0] dest,
                                input logic [2:0] last, input logic [2:0] in_dom,
                                input logic [2:0] out_dom, input logic [2:0] ordy);
      bus.req_val    = val;
      bus.req_dest   = dest;
      bus.req_last   = last;
      bus.in_domain  = in_dom;
      bus.out_domain = out_dom;
      bus.out_rdy    = ordy;
      #2;
   endtask

   initial begin
      own_seq = '{0, 1, 2, 0};
      #1 reset_n = 1'b0;
      applyStimulus(3'b000, 6'h3f, 3'b000, 3'b000, 3'b000, 3'b000);
      checkOutput("rst_out_val", bus.out_val, 0);
      checkOutput("rst_req_rdy", bus.req_rdy, 0);
      checkOutput("rst_sel0", bus.sel0, 0);
      checkOutput("rst_sel1", bus.sel1, 0);
      checkOutput("rst_sel2", bus.sel2, 0);
      checkOutput("rst_viol_val", bus.viol_val, 0);
      checkOutput("rst_viol_src", bus.viol_src, 0);
      checkOutput("rst_viol_dest", bus.viol_dest, 0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // Three L inputs contend for output 2 with single-beat packets
      applyStimulus(3'b111, 6'b101010, 3'b111, 3'b000, 3'b000, 3'b100);
      checkOutput("cont_idle_val", bus.out_val, 0);
      for (int k = 0; k < 4; k++) begin
         tick();
         checkOutput("cont_sel2", bus.sel2, own_seq[k]);
         checkOutput("cont_rdy", bus.req_rdy, 1 << own_seq[k]);
         checkOutput("cont_val", bus.out_val, 3'b100);
         tick();
         checkOutput("cont_gap_val", bus.out_val, 0);
         checkOutput("cont_hold_sel2", bus.sel2, own_seq[k]);
      end
      applyStimulus(3'b000, 6'h3f, 3'b000, 3'b000, 3'b000, 3'b000);

      // H input 0 aimed at L output 0
      applyStimulus(3'b001, 6'b111100, 3'b001, 3'b001, 3'b000, 3'b111);
      checkOutput("fd_rdy_a", bus.req_rdy, 0);
      checkOutput("fd_viol_pre", bus.viol_val, 0);
      tick();
      checkOutput("fd_viol_val", bus.viol_val, 1);
      checkOutput("fd_viol_src", bus.viol_src, 0);
      checkOutput("fd_viol_dest", bus.viol_dest, 0);
      checkOutput("fd_rdy_b", bus.req_rdy, 0);
      tick();
      checkOutput("fd_viol_once", bus.viol_val, 0);
      checkOutput("fd_rdy_c", bus.req_rdy, 0);
      tick();
      checkOutput("fd_rdy_d", bus.req_rdy, 0);
      checkOutput("fd_out_val", bus.out_val, 0);
      applyStimulus(3'b000, 6'h3f, 3'b000, 3'b000, 3'b000, 3'b000);

      // H input 2 on H output 2, then output 2 drops to L mid-packet
      applyStimulus(3'b100, 6'b101111, 3'b000, 3'b100, 3'b100, 3'b100);
      checkOutput("flip_idle_val", bus.out_val, 0);
      tick();
      checkOutput("flip_val", bus.out_val, 3'b100);
      checkOutput("flip_sel2", bus.sel2, 2);
      checkOutput("flip_rdy", bus.req_rdy, 3'b100);
      tick();
      applyStimulus(3'b100, 6'b101111, 3'b000, 3'b100, 3'b000, 3'b100);
      checkOutput("flip_drop_val", bus.out_val, 0);
      checkOutput("flip_drop_rdy", bus.req_rdy, 0);
      checkOutput("flip_viol_pre", bus.viol_val, 0);
      tick();
      checkOutput("flip_viol_val", bus.viol_val, 1);
      checkOutput("flip_viol_src", bus.viol_src, 2);
      checkOutput("flip_viol_dest", bus.viol_dest, 2);
      applyStimulus(3'b100, 6'b101111, 3'b100, 3'b100, 3'b100, 3'b100);
      checkOutput("flip_fsm_idle", bus.out_val, 0);
      tick();
      checkOutput("flip_regrant_val", bus.out_val, 3'b100);
      checkOutput("flip_regrant_sel2", bus.sel2, 2);
      checkOutput("flip_viol_clear", bus.viol_val, 0);
      tick();
      applyStimulus(3'b000, 6'h3f, 3'b000, 3'b000, 3'b000, 3'b000);

      // H input 1 sends 4 beats to H output 0 under 1010 backpressure, L input 2 waits
      applyStimulus(3'b110, 6'b000011, 3'b100, 3'b010, 3'b001, 3'b001);
      checkOutput("mb_idle_val", bus.out_val, 0);
      for (int k = 0; k < 7; k++) begin
         tick();
         applyStimulus(3'b110, 6'b000011, (k == 6) ? 3'b110 : 3'b100, 3'b010, 3'b001,
                       (k % 2 == 0) ? 3'b001 : 3'b000);
         checkOutput("mb_val", bus.out_val, 3'b001);
         checkOutput("mb_sel0", bus.sel0, 1);
         checkOutput("mb_rdy", bus.req_rdy, (k % 2 == 0) ? 3'b010 : 3'b000);
         fires += int'(bus.req_rdy[1]);
      end
      checkOutput("mb_fires", fires, 4);
      tick();
      applyStimulus(3'b110, 6'b000011, 3'b100, 3'b010, 3'b001, 3'b001);
      checkOutput("mb_rel_val", bus.out_val, 0);
      checkOutput("mb_rel_rdy", bus.req_rdy, 0);
      checkOutput("mb_rel_sel0", bus.sel0, 1);
      tick();
      checkOutput("mb_next_sel0", bus.sel0, 2);
      checkOutput("mb_next_rdy", bus.req_rdy, 3'b100);
      tick();
      applyStimulus(3'b000, 6'h3f, 3'b000, 3'b000, 3'b000, 3'b000);

      // Input 1 streams a long packet to output 1 against single-beat competitor 2
      applyStimulus(3'b110, 6'b010111, 3'b100, 3'b000, 3'b000, 3'b010);
      checkOutput("fr_idle_val", bus.out_val, 0);
      for (int k = 0; k < 4; k++) begin
         tick();
         checkOutput("fr_val", bus.out_val, 3'b010);
         checkOutput("fr_rdy", bus.req_rdy, 3'b010);
         checkOutput("fr_sel1", bus.sel1, 1);
      end
      tick();
      checkOutput("fr_rel_val", bus.out_val, 0);
      checkOutput("fr_rel_sel1", bus.sel1, 1);
      tick();
      checkOutput("fr_comp_sel1", bus.sel1, 2);
      checkOutput("fr_comp_rdy", bus.req_rdy, 3'b100);
      tick();
      checkOutput("fr_gap_val", bus.out_val, 0);
      tick();
      checkOutput("fr_regrant_sel1", bus.sel1, 1);
      checkOutput("fr_regrant_rdy", bus.req_rdy, 3'b010);

      // Asynchronous reset while output 1 is mid-packet
      reset_n = 1'b0;
      #1;
      checkOutput("rmid_out_val", bus.out_val, 0);
      checkOutput("rmid_req_rdy", bus.req_rdy, 0);
      checkOutput("rmid_sel1", bus.sel1, 0);
      checkOutput("rmid_viol_src", bus.viol_src, 0);
      checkOutput("rmid_viol_dest", bus.viol_dest, 0);
      applyStimulus(3'b101, 6'b011101, 3'b101, 3'b000, 3'b000, 3'b010);
      reset_n = 1'b1;
      tick();
      checkOutput("rmid_first_rdy", bus.req_rdy, 3'b001);
      checkOutput("rmid_first_sel1", bus.sel1, 0);
      checkOutput("rmid_first_val", bus.out_val, 3'b010);
      tick();
      applyStimulus(3'b000, 6'h3f, 3'b000, 3'b000, 3'b000, 3'b000);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
